// File: rtl/alu_sequencer.sv
// Purpose: control unit for the 8-bit accumulator ALU; owns acc, operand latch, op strobes and Z/C/N flags.
// Latency: legal op retires (done) 3 cycles after handshake, NOP/illegal 1 cycle after; strobe in cycle T+2.
// Backpressure: instr_ready only in IDLE (and not in reset); requester holds instr_valid until accepted.
module alu_sequencer #(
   parameter int WIDTH = 8,
   parameter int OPW   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [OPW-1:0]   instr_op,
   input  logic [WIDTH-1:0] instr_operand,
   output logic [WIDTH-1:0] alu_acc,
   output logic [WIDTH-1:0] alu_bus,
   input  logic [WIDTH-1:0] alu_z,
   output logic             op_add,
   output logic             op_sub,
   output logic             op_comp,
   output logic             op_and,
   output logic             op_or,
   output logic             op_xor,
   output logic             done,
   output logic             err,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_n
);

   typedef enum logic [1:0] {IDLE, SETUP, EXEC, WB} state_t;

   localparam logic [OPW-1:0] OP_NOP = OPW'(0);
   localparam logic [OPW-1:0] OP_LDA = OPW'(1);
   localparam logic [OPW-1:0] OP_ADD = OPW'(2);
   localparam logic [OPW-1:0] OP_SUB = OPW'(3);
   localparam logic [OPW-1:0] OP_CMP = OPW'(4);
   localparam logic [OPW-1:0] OP_AND = OPW'(5);
   localparam logic [OPW-1:0] OP_OR  = OPW'(6);
   localparam logic [OPW-1:0] OP_XOR = OPW'(7);

   // strobe vector bit positions
   localparam int SB_ADD = 0;
   localparam int SB_SUB = 1;
   localparam int SB_CMP = 2;
   localparam int SB_AND = 3;
   localparam int SB_OR  = 4;
   localparam int SB_XOR = 5;

   state_t           state_q, state_d;
   logic [OPW-1:0]   op_q, op_d;
   logic [WIDTH-1:0] bus_q, bus_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [5:0]       strb_q, strb_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             fz_q, fz_d;
   logic             fc_q, fc_d;
   logic             fn_q, fn_d;

   // Flag arithmetic is done here at WIDTH+1 bits; the ALU has no compare path,
   // so CMP flags cannot come from alu_z. Top bit of diff_w is the borrow.
   logic [WIDTH:0]   sum_w;
   logic [WIDTH:0]   diff_w;
   logic [WIDTH-1:0] res_w;
   logic             carry_w;
   logic             upd_w;
   logic             illegal_w;

   assign sum_w     = {1'b0, acc_q} + {1'b0, bus_q};
   assign diff_w    = {1'b0, acc_q} - {1'b0, bus_q};
   assign illegal_w = (instr_op > OP_XOR);

   assign instr_ready = (state_q == IDLE) && !rst;
   assign alu_acc     = acc_q;
   assign alu_bus     = bus_q;
   assign op_add      = strb_q[SB_ADD];
   assign op_sub      = strb_q[SB_SUB];
   assign op_comp     = strb_q[SB_CMP];
   assign op_and      = strb_q[SB_AND];
   assign op_or       = strb_q[SB_OR];
   assign op_xor      = strb_q[SB_XOR];
   assign done        = done_q;
   assign err         = err_q;
   assign flag_z      = fz_q;
   assign flag_c      = fc_q;
   assign flag_n      = fn_q;

   // Next-state, strobe decode and write-back. Results land on the edge into WB
   // so acc and flags are already updated while done is high.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      bus_d   = bus_q;
      acc_d   = acc_q;
      strb_d  = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      fz_d    = fz_q;
      fc_d    = fc_q;
      fn_d    = fn_q;
      res_w   = '0;
      carry_w = 1'b0;
      upd_w   = 1'b0;

      case (state_q)
         IDLE: begin
            if (instr_valid && instr_ready) begin
               op_d  = instr_op;
               bus_d = instr_operand;
               if (instr_op == OP_NOP || illegal_w) begin
                  // nothing for the ALU to do: retire on the next cycle
                  state_d = WB;
                  done_d  = 1'b1;
                  err_d   = illegal_w;
               end else begin
                  state_d = SETUP;
               end
            end
         end

         SETUP: begin
            state_d = EXEC;
            case (op_q)
               OP_ADD:  strb_d[SB_ADD] = 1'b1;
               OP_SUB:  strb_d[SB_SUB] = 1'b1;
               OP_CMP:  strb_d[SB_CMP] = 1'b1;
               OP_AND:  strb_d[SB_AND] = 1'b1;
               OP_OR:   strb_d[SB_OR]  = 1'b1;
               OP_XOR:  strb_d[SB_XOR] = 1'b1;
               default: strb_d = '0;
            endcase
         end

         EXEC: begin
            state_d = WB;
            done_d  = 1'b1;
            upd_w   = 1'b1;
            case (op_q)
               OP_LDA: begin acc_d = bus_q; res_w = bus_q;                             end
               OP_ADD: begin acc_d = alu_z; res_w = sum_w[WIDTH-1:0];  carry_w = sum_w[WIDTH];  end
               OP_SUB: begin acc_d = alu_z; res_w = diff_w[WIDTH-1:0]; carry_w = diff_w[WIDTH]; end
               OP_CMP: begin                res_w = diff_w[WIDTH-1:0]; carry_w = diff_w[WIDTH]; end
               OP_AND: begin acc_d = alu_z; res_w = acc_q & bus_q;                     end
               OP_OR:  begin acc_d = alu_z; res_w = acc_q | bus_q;                     end
               OP_XOR: begin acc_d = alu_z; res_w = acc_q ^ bus_q;                     end
               default: upd_w = 1'b0;
            endcase
            if (upd_w) begin
               fz_d = (res_w == '0);
               fc_d = carry_w;
               fn_d = res_w[WIDTH-1];
            end
         end

         WB: begin
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // State register; reset discards any in-flight instruction without retiring it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= '0;
         bus_q   <= '0;
         acc_q   <= '0;
         strb_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         fz_q    <= 1'b0;
         fc_q    <= 1'b0;
         fn_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         bus_q   <= bus_d;
         acc_q   <= acc_d;
         strb_q  <= strb_d;
         done_q  <= done_d;
         err_q   <= err_d;
         fz_q    <= fz_d;
         fc_q    <= fc_d;
         fn_q    <= fn_d;
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed scenarios followed by random instructions.
// A behavioural ALU drives alu_z from the strobes; acc/flags are predicted with plain integer arithmetic.
// Outputs are sampled 1 time unit after each rising edge; inputs change at that point too.
module tb_alu_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       instr_valid;
   logic       instr_ready;
   logic [3:0] instr_op;
   logic [7:0] instr_operand;
   logic [7:0] alu_acc;
   logic [7:0] alu_bus;
   logic [7:0] alu_z;
   logic       op_add, op_sub, op_comp, op_and, op_or, op_xor;
   logic       done, err;
   logic       flag_z, flag_c, flag_n;

   int checks = 0;
   int errors = 0;

   // reference state
   int m_acc;
   bit m_z, m_c, m_n;

   logic [7:0] junk_q;
   logic [5:0] strobes;

   assign strobes = {op_xor, op_or, op_and, op_comp, op_sub, op_add};

   alu_sequencer #(.WIDTH(8), .OPW(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr_op      (instr_op),
      .instr_operand (instr_operand),
      .alu_acc       (alu_acc),
      .alu_bus       (alu_bus),
      .alu_z         (alu_z),
      .op_add        (op_add),
      .op_sub        (op_sub),
      .op_comp       (op_comp),
      .op_and        (op_and),
      .op_or         (op_or),
      .op_xor        (op_xor),
      .done          (done),
      .err           (err),
      .flag_z        (flag_z),
      .flag_c        (flag_c),
      .flag_n        (flag_n)
   );

   always #5 clk = ~clk;

   // unrelated value on alu_z whenever no computing strobe is high
   always @(posedge clk) junk_q <= 8'($urandom);

   // behavioural ALU: no compare datapath, so CMP yields junk
   always_comb begin
      alu_z = junk_q;
      if (op_add)      alu_z = alu_acc + alu_bus;
      else if (op_sub) alu_z = alu_acc - alu_bus;
      else if (op_and) alu_z = alu_acc & alu_bus;
      else if (op_or)  alu_z = alu_acc | alu_bus;
      else if (op_xor) alu_z = alu_acc ^ alu_bus;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [5:0] strobe_of(input int op);
      case (op)
         2: return 6'b000001;
         3: return 6'b000010;
         4: return 6'b000100;
         5: return 6'b001000;
         6: return 6'b010000;
         7: return 6'b100000;
         default: return 6'b000000;
      endcase
   endfunction

   // reference model: effect of one retired instruction on acc and flags
   task automatic ref_exec(input int op, input int b);
      int a = m_acc;
      int r = 0;
      bit upd = 1'b1;
      case (op)
         1: begin r = b;                    m_c = 1'b0;    m_acc = r; end
         2: begin r = (a + b) % 256;        m_c = (a + b) > 255; m_acc = r; end
         3: begin r = (a - b + 256) % 256;  m_c = (a < b); m_acc = r; end
         4: begin r = (a - b + 256) % 256;  m_c = (a < b);            end
         5: begin r = a & b;                m_c = 1'b0;    m_acc = r; end
         6: begin r = a | b;                m_c = 1'b0;    m_acc = r; end
         7: begin r = a ^ b;                m_c = 1'b0;    m_acc = r; end
         default: upd = 1'b0;
      endcase
      if (upd) begin
         m_z = (r == 0);
         m_n = (r >= 128);
      end
   endtask

   // Issue one instruction, follow it to retirement and check everything on the way.
   // Returns one cycle after the done pulse with instr_valid low.
   task automatic do_instr(input int op, input int opnd, input bit hold);
      int n;
      int k;
      int lat;
      int prev_acc;
      bit seen;
      instr_op      = op[3:0];
      instr_operand = opnd[7:0];
      instr_valid   = 1'b1;
      n = 0;
      while (instr_ready !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk("handshake_wait", 32'(n < 20), 32'd1);
      if (n >= 20) begin
         instr_valid = 1'b0;
         return;
      end
      prev_acc = m_acc;
      lat = (op >= 1 && op <= 7) ? 3 : 1;
      step();
      k = 1;
      seen = 1'b0;
      if (!hold) begin
         instr_valid   = 1'b0;
         instr_op      = 4'($urandom);
         instr_operand = 8'($urandom);
      end
      while (!seen && k <= 6) begin
         chk($sformatf("strobe_op%0d_k%0d", op, k), strobes,
             (k == 2 && lat == 3) ? strobe_of(op) : 6'b0);
         if (done === 1'b1) begin
            seen = 1'b1;
         end else begin
            chk($sformatf("bus_stable_k%0d", k), alu_bus, opnd[7:0]);
            chk($sformatf("acc_stable_k%0d", k), alu_acc, prev_acc[7:0]);
            chk($sformatf("ready_busy_k%0d", k), instr_ready, 1'b0);
            step();
            k++;
         end
      end
      chk($sformatf("done_latency_op%0d", op), k, lat);
      ref_exec(op, opnd);
      chk($sformatf("err_op%0d", op), err, 32'(op > 7));
      chk($sformatf("acc_op%0d", op), alu_acc, m_acc[7:0]);
      chk($sformatf("flags_op%0d", op), {flag_z, flag_c, flag_n}, {m_z, m_c, m_n});
      chk("ready_in_done", instr_ready, 1'b0);
      step();
      chk("ready_after_done", instr_ready, 1'b1);
      chk("done_one_cycle", {done, err}, 2'b00);
      instr_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst           = 1'b1;
      instr_valid   = 1'b0;
      instr_op      = 4'd0;
      instr_operand = 8'd0;
      m_acc = 0; m_z = 1'b0; m_c = 1'b0; m_n = 1'b0;

      // reset held two cycles
      step();
      chk("rst_ready", instr_ready, 1'b0);
      chk("rst_acc", alu_acc, 8'h00);
      chk("rst_bus", alu_bus, 8'h00);
      chk("rst_strobes", strobes, 6'b0);
      chk("rst_done_err", {done, err}, 2'b00);
      chk("rst_flags", {flag_z, flag_c, flag_n}, 3'b000);
      step();
      rst = 1'b0;
      #1;
      chk("ready_after_rst", instr_ready, 1'b1);

      // directed scenarios
      do_instr(1, 8'h3C, 1'b0);
      chk("lda_3c_acc", alu_acc, 8'h3C);
      chk("lda_3c_flags", {flag_z, flag_c, flag_n}, 3'b000);

      do_instr(1, 8'hFF, 1'b0);
      do_instr(2, 8'h01, 1'b0);
      chk("add_wrap_acc", alu_acc, 8'h00);
      chk("add_wrap_flags", {flag_z, flag_c, flag_n}, 3'b110);

      do_instr(1, 8'h10, 1'b0);
      do_instr(4, 8'h20, 1'b0);
      chk("cmp_acc_kept", alu_acc, 8'h10);
      chk("cmp_flags", {flag_z, flag_c, flag_n}, 3'b011);

      do_instr(1, 8'hF0, 1'b0);
      do_instr(5, 8'h3C, 1'b0);
      chk("and_acc", alu_acc, 8'h30);
      do_instr(7, 8'h30, 1'b0);
      chk("xor_acc", alu_acc, 8'h00);
      chk("xor_flags", {flag_z, flag_c, flag_n}, 3'b100);

      // illegal opcode with valid held throughout
      do_instr(1, 8'h81, 1'b0);
      do_instr(4'hA, 8'h55, 1'b1);
      chk("illegal_acc", alu_acc, 8'h81);
      chk("illegal_flags", {flag_z, flag_c, flag_n}, 3'b001);
      do_instr(0, 8'h12, 1'b0);
      do_instr(3, 8'h01, 1'b1);
      do_instr(6, 8'h0F, 1'b0);

      // reset during the EXEC cycle of an ADD
      do_instr(1, 8'h40, 1'b0);
      instr_op      = 4'd2;
      instr_operand = 8'h11;
      instr_valid   = 1'b1;
      chk("rst_exec_ready", instr_ready, 1'b1);
      step();
      instr_valid = 1'b0;
      step();
      chk("rst_exec_add_strobe", strobes, 6'b000001);
      rst = 1'b1;
      step();
      chk("rst_exec_strobes", strobes, 6'b0);
      chk("rst_exec_acc", alu_acc, 8'h00);
      chk("rst_exec_flags", {flag_z, flag_c, flag_n}, 3'b000);
      chk("rst_exec_done", {done, err}, 2'b00);
      chk("rst_exec_ready_low", instr_ready, 1'b0);
      rst = 1'b0;
      m_acc = 0; m_z = 1'b0; m_c = 1'b0; m_n = 1'b0;
      step();
      chk("rst_exec_ready_back", instr_ready, 1'b1);
      chk("rst_exec_no_done", done, 1'b0);

      // random instruction stream, biased toward legal opcodes
      for (int i = 0; i < 150; i++) begin
         int op;
         op = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 15));
         do_instr(op, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
